// File: rtl/rgb_timing_gen_if.sv
// Pixel request / video output bundle between the timing generator, the
// upstream frame renderer (rgb_in) and the RGB encoder (sync, de, rgb_out).
interface rgb_timing_gen_if #(
  parameter int COORD_W = 12,
  parameter int RGB_W   = 24
);

  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;
  logic               req_valid;
  logic [RGB_W-1:0]   rgb_in;
  logic [RGB_W-1:0]   rgb_out;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               frame_start;

  // Timing generator side: issues requests, receives pixels, drives video.
  modport master (
    output req_x,
    output req_y,
    output req_valid,
    input  rgb_in,
    output rgb_out,
    output hsync,
    output vsync,
    output de,
    output frame_start
  );

  // Renderer/encoder side.
  modport slave (
    input  req_x,
    input  req_y,
    input  req_valid,
    output rgb_in,
    input  rgb_out,
    input  hsync,
    input  vsync,
    input  de,
    input  frame_start
  );

endinterface

// File: rtl/rgb_timing_gen.sv
// Programmable raster timing generator: requests pixels LATENCY cycles ahead
// and re-aligns the returned data with hsync/vsync/de/frame_start.
module rgb_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int COORD_W  = 12,
  parameter int RGB_W    = 24,
  parameter int LATENCY  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  rgb_timing_gen_if.master    bus
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int VS_FIRST = V_ACTIVE + V_FP;

  // Raster boundaries as counter-width constants so every compare is width-matched.
  localparam logic [COORD_W-1:0] H_LAST_C     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST_C     = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_C      = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C      = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST_C   = COORD_W'(HS_FIRST);
  localparam logic [COORD_W-1:0] HS_LAST_C    = COORD_W'(HS_FIRST + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST_C   = COORD_W'(VS_FIRST);
  localparam logic [COORD_W-1:0] VS_LAST_C    = COORD_W'(VS_FIRST + V_SYNC - 1);

  // Polarity-free timing flags; polarity is applied only at the pins.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } flags_t;

  logic [COORD_W-1:0]   h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0]   v_cnt_q, v_cnt_d;
  flags_t               raw_flags;
  flags_t [LATENCY:0]   pipe_q, pipe_d;
  logic [RGB_W-1:0]     rgb_q, rgb_d;

  // Raster counters: h wraps every line, v advances on the h wrap.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    h_cnt_d = h_cnt_q + COORD_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST_C) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + COORD_W'(1);
    end
  end

  // Counter decode; vs depends only on v_cnt so it switches at h_cnt==0.
  always_comb begin
    raw_flags    = '0;
    raw_flags.de = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    raw_flags.hs = (h_cnt_q >= HS_FIRST_C) && (h_cnt_q <= HS_LAST_C);
    raw_flags.vs = (v_cnt_q >= VS_FIRST_C) && (v_cnt_q <= VS_LAST_C);
    raw_flags.fs = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Stage k holds the flags of the request issued k+1 cycles ago, so
  // pipe_d[LATENCY] is the flag set whose pixel is on rgb_in right now.
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = raw_flags;
    for (int k = 1; k <= LATENCY; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
    rgb_d = pipe_d[LATENCY].de ? bus.rgb_in : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      // NOTE: the flag pipeline is reset like any control state, so the outputs come up blank with no stale sync.
      pipe_q  <= '0;
      rgb_q   <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      pipe_q  <= pipe_d;
      rgb_q   <= rgb_d;
    end
  end

  assign bus.req_x       = h_cnt_q;
  assign bus.req_y       = v_cnt_q;
  assign bus.req_valid   = raw_flags.de;
  assign bus.rgb_out     = rgb_q;
  assign bus.de          = pipe_q[LATENCY].de;
  assign bus.frame_start = pipe_q[LATENCY].fs;
  assign bus.hsync       = pipe_q[LATENCY].hs ? HS_POL : ~HS_POL;
  assign bus.vsync       = pipe_q[LATENCY].vs ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_rgb_timing_gen.sv
// Self-checking bench: a small 8x6 raster (LATENCY=2) and the default 1650x750
// raster (LATENCY=0), both compared every cycle against an arithmetic raster model.
module tb_rgb_timing_gen;

  typedef struct packed {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, lat;
  } tim_t;

  typedef struct packed {
    logic [11:0] rx, ry;
    logic        rv;
    logic [11:0] ox, oy;
    logic        de, hs, vs, fs;
  } exp_t;

  localparam tim_t TA = '{ha:4,    hfp:1,   hs:2,  hbp:1,   va:3,   vfp:1, vs:1, vbp:1,  lat:2};
  localparam tim_t TB = '{ha:1280, hfp:110, hs:40, hbp:220, va:720, vfp:5, vs:5, vbp:20, lat:0};

  logic clk = 1'b0;
  logic rst_na, rst_nb;
  always #5 clk = ~clk;

  rgb_timing_gen_if #(.COORD_W(12), .RGB_W(24)) bus_a ();
  rgb_timing_gen_if #(.COORD_W(12), .RGB_W(24)) bus_b ();

  rgb_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .COORD_W(12), .RGB_W(24), .LATENCY(2)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_na),
    .bus  (bus_a)
  );

  rgb_timing_gen #(
    .COORD_W(12), .RGB_W(24), .LATENCY(0)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_nb),
    .bus  (bus_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Raster model: cycle t issues request number t and outputs request t-lat-1.
  function automatic exp_t model(input tim_t p, input int t);
    exp_t m;
    int ht, vt, fl, rp, c, op, ox, oy;
    ht = p.ha + p.hfp + p.hs + p.hbp;
    vt = p.va + p.vfp + p.vs + p.vbp;
    fl = ht * vt;
    rp = t % fl;
    m = '0;
    m.rx = 12'(rp % ht);
    m.ry = 12'(rp / ht);
    m.rv = ((rp % ht) < p.ha) && ((rp / ht) < p.va);
    c = t - p.lat - 1;
    if (c >= 0) begin
      op = c % fl;
      ox = op % ht;
      oy = op / ht;
      m.ox = 12'(ox);
      m.oy = 12'(oy);
      m.de = (ox < p.ha) && (oy < p.va);
      m.hs = (ox >= p.ha + p.hfp) && (ox < p.ha + p.hfp + p.hs);
      m.vs = (oy >= p.va + p.vfp) && (oy < p.va + p.vfp + p.vs);
      m.fs = (op == 0);
    end
    return m;
  endfunction

  // Cycle index since the last reset release; stays 0 while in reset.
  int cyc_a, cyc_b;
  always @(posedge clk or negedge rst_na)
    if (!rst_na) cyc_a <= 0; else cyc_a <= cyc_a + 1;
  always @(posedge clk or negedge rst_nb)
    if (!rst_nb) cyc_b <= 0; else cyc_b <= cyc_b + 1;

  // Stimulus modes for A: 0 raster {y,x}, 1 random, 2 constant white, 3 cycle tag.
  int          mode_a = 3;
  logic [23:0] log_a [int];
  int          mode_log_a [int];
  logic [23:0] log_b [int];

  initial begin
    bus_a.rgb_in = '0;
    bus_b.rgb_in = '0;
    forever begin
      logic [23:0] va, vb;
      exp_t        rq;
      @(negedge clk);
      case (mode_a)
        0: begin
          va = '0;
          if (cyc_a >= TA.lat) begin
            rq = model(TA, cyc_a - TA.lat);
            va = {rq.ry, rq.rx};
          end
        end
        1:       va = 24'($urandom);
        2:       va = 24'hFFFFFF;
        default: va = 24'hA50000 + 24'(cyc_a);
      endcase
      vb = 24'($urandom);
      log_a[cyc_a]      = va;
      mode_log_a[cyc_a] = mode_a;
      log_b[cyc_b]      = vb;
      bus_a.rgb_in      = va;
      bus_b.rgb_in      = vb;
    end
  end

  // Per-cycle compare process, sampled on the falling edge.
  bit          run_cmp = 1'b0;
  int          run_a, run_b, last_fs_a;
  bit          have_fs_a;
  logic [11:0] max_xb = '0;

  always @(negedge clk) begin
    exp_t ea, eb;
    if (run_cmp) begin
      ea = model(TA, cyc_a);
      check("a_req_x",     32'(bus_a.req_x),     32'(ea.rx));
      check("a_req_y",     32'(bus_a.req_y),     32'(ea.ry));
      check("a_req_valid", 32'(bus_a.req_valid), 32'(ea.rv));
      check("a_de",        32'(bus_a.de),        32'(ea.de));
      check("a_hsync",     32'(bus_a.hsync),     32'(ea.hs));
      check("a_vsync",     32'(bus_a.vsync),     32'(ea.vs));
      check("a_fs",        32'(bus_a.frame_start), 32'(ea.fs));
      if (ea.de) begin
        check("a_rgb", 32'(bus_a.rgb_out), 32'(log_a[cyc_a-1]));
        if (mode_log_a[cyc_a-1] == 0)
          check("a_raster_xy", 32'(bus_a.rgb_out), 32'({ea.oy, ea.ox}));
      end else begin
        check("a_rgb_blank", 32'(bus_a.rgb_out), 32'h0);
      end

      eb = model(TB, cyc_b);
      check("b_req_x",     32'(bus_b.req_x),     32'(eb.rx));
      check("b_req_y",     32'(bus_b.req_y),     32'(eb.ry));
      check("b_req_valid", 32'(bus_b.req_valid), 32'(eb.rv));
      check("b_de",        32'(bus_b.de),        32'(eb.de));
      check("b_hsync",     32'(bus_b.hsync),     32'(eb.hs));
      check("b_vsync",     32'(bus_b.vsync),     32'(eb.vs));
      check("b_fs",        32'(bus_b.frame_start), 32'(eb.fs));
      if (eb.de) check("b_rgb", 32'(bus_b.rgb_out), 32'(log_b[cyc_b-1]));
      else       check("b_rgb_blank", 32'(bus_b.rgb_out), 32'h0);
      if (bus_b.req_x > max_xb) max_xb = bus_b.req_x;

      // Structural counts taken straight from the DUT outputs.
      if (!rst_na) begin
        run_a     = 0;
        have_fs_a = 1'b0;
      end else begin
        if (bus_a.de) run_a++;
        else if (run_a != 0) begin
          check("a_de_per_line", 32'(run_a), 32'd4);
          run_a = 0;
        end
        if (bus_a.frame_start) begin
          if (have_fs_a) check("a_fs_period", 32'(cyc_a - last_fs_a), 32'd48);
          last_fs_a = cyc_a;
          have_fs_a = 1'b1;
        end
      end
      if (bus_b.de) run_b++;
      else if (run_b != 0) begin
        check("b_de_per_line", 32'(run_b), 32'd1280);
        run_b = 0;
      end
    end
  end

  task automatic wait_a(input int n);
    int k = 0;
    while (cyc_a != n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (cyc_a != n) check("a_wait_timeout", 32'(cyc_a), 32'(n));
  endtask

  task automatic wait_b(input int n);
    int k = 0;
    while (cyc_b != n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (cyc_b != n) check("b_wait_timeout", 32'(cyc_b), 32'(n));
  endtask

  initial begin
    rst_na = 1'b0;
    rst_nb = 1'b0;
    run_a = 0; run_b = 0; last_fs_a = 0; have_fs_a = 1'b0;
    repeat (2) @(negedge clk);
    run_cmp = 1'b1;
    @(negedge clk);
    rst_na = 1'b1;
    rst_nb = 1'b1;

    // Reset release: blank for cycles 0..2, first pixel in cycle 3.
    for (int t = 0; t < 3; t++) begin
      wait_a(t);
      check("lit_a_idle_de",  32'(bus_a.de),          32'd0);
      check("lit_a_idle_fs",  32'(bus_a.frame_start), 32'd0);
      check("lit_a_idle_rgb", 32'(bus_a.rgb_out),     32'd0);
      if (t == 0) check("lit_b_c0_de", 32'(bus_b.de), 32'd0);
      if (t == 1) begin
        check("lit_b_c1_de",  32'(bus_b.de),          32'd1);
        check("lit_b_c1_fs",  32'(bus_b.frame_start), 32'd1);
        check("lit_b_c1_rgb", 32'(bus_b.rgb_out),     32'(log_b[0]));
      end
    end
    wait_a(3);
    check("lit_a_c3_de",  32'(bus_a.de),          32'd1);
    check("lit_a_c3_fs",  32'(bus_a.frame_start), 32'd1);
    check("lit_a_c3_rgb", 32'(bus_a.rgb_out),     32'hA50002);
    wait_a(7);  check("lit_a_hs_c7",  32'(bus_a.hsync), 32'd0);
    wait_a(8);  check("lit_a_hs_c8",  32'(bus_a.hsync), 32'd1);
    wait_a(9);  check("lit_a_hs_c9",  32'(bus_a.hsync), 32'd1);
    wait_a(10); check("lit_a_hs_c10", 32'(bus_a.hsync), 32'd0);
    wait_a(34); check("lit_a_vs_c34", 32'(bus_a.vsync), 32'd0);
    wait_a(35); check("lit_a_vs_c35", 32'(bus_a.vsync), 32'd1);
    wait_a(42); check("lit_a_vs_c42", 32'(bus_a.vsync), 32'd1);
    wait_a(43); check("lit_a_vs_c43", 32'(bus_a.vsync), 32'd0);
    wait_a(50); check("lit_a_fs_c50", 32'(bus_a.frame_start), 32'd0);
    wait_a(51); check("lit_a_fs_c51", 32'(bus_a.frame_start), 32'd1);

    mode_a = 0; wait_a(160);
    mode_a = 1; wait_a(260);
    mode_a = 2; wait_a(360);
    mode_a = 1;

    // Mid-frame asynchronous reset while the request is at v=1, h=2.
    begin
      int k = 0;
      while ((cyc_a % 48) != 10 && k < 200) begin
        @(negedge clk);
        k++;
      end
      check("a_find_v1h2", 32'(cyc_a % 48), 32'd10);
    end
    check("lit_a_pre_rst_x", 32'(bus_a.req_x), 32'd2);
    check("lit_a_pre_rst_y", 32'(bus_a.req_y), 32'd1);
    #2 rst_na = 1'b0;
    #1;
    check("rst_req_x",     32'(bus_a.req_x),       32'd0);
    check("rst_req_y",     32'(bus_a.req_y),       32'd0);
    check("rst_req_valid", 32'(bus_a.req_valid),   32'd1);
    check("rst_rgb",       32'(bus_a.rgb_out),     32'd0);
    check("rst_de",        32'(bus_a.de),          32'd0);
    check("rst_hsync",     32'(bus_a.hsync),       32'd0);
    check("rst_vsync",     32'(bus_a.vsync),       32'd0);
    check("rst_fs",        32'(bus_a.frame_start), 32'd0);
    repeat (2) @(negedge clk);
    rst_na = 1'b1;
    wait_a(2); check("lit_a_rel_c2_fs", 32'(bus_a.frame_start), 32'd0);
    wait_a(3);
    check("lit_a_rel_c3_fs",  32'(bus_a.frame_start), 32'd1);
    check("lit_a_rel_c3_rgb", 32'(bus_a.rgb_out),     32'(log_a[2]));
    wait_a(150);

    // Default raster, LATENCY=0: hsync window [1390,1430) seen one cycle later.
    wait_b(1390); check("lit_b_hs_c1390", 32'(bus_b.hsync), 32'd0);
    wait_b(1391); check("lit_b_hs_c1391", 32'(bus_b.hsync), 32'd1);
    wait_b(1430); check("lit_b_hs_c1430", 32'(bus_b.hsync), 32'd1);
    wait_b(1431); check("lit_b_hs_c1431", 32'(bus_b.hsync), 32'd0);
    wait_b(3400);
    check("b_req_x_max", 32'(max_xb), 32'd1649);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rgb_timing_gen.md
# rgb_timing_gen

Video timing generator for the RGB output path. It runs directly on the pixel clock produced by the RGB clock PLL and walks a programmable horizontal/vertical raster. It issues pixel-coordinate requests to the upstream frame renderer a fixed number of cycles ahead of display. It then re-aligns the returned pixel data with hsync/vsync/de so the outputs can drive the RGB/encoder interface directly.

## Interface
- `H_ACTIVE`, 1280: visible pixels per line
- `H_FP`, 110: horizontal front porch, in pixels
- `H_SYNC`, 40: hsync width, in pixels
- `H_BP`, 220: horizontal back porch, in pixels
- `V_ACTIVE`, 720: visible lines per frame
- `V_FP`, 5: vertical front porch, in lines
- `V_SYNC`, 5: vsync width, in lines
- `V_BP`, 20: vertical back porch, in lines
- `HS_POL`, 1: hsync active level
- `VS_POL`, 1: vsync active level
- `COORD_W`, 12: width of counters and coordinates; must hold H_TOTAL-1 and V_TOTAL-1
- `RGB_W`, 24: pixel data width
- `LATENCY`, 2: cycles from request to `rgb_in` valid; 0..15
- `clk` in 1: pixel clock, from PLL `clkout`
- `rst_n` in 1: asynchronous, active-low reset
- `req_x` out COORD_W: requested column
- `req_y` out COORD_W: requested row
- `req_valid` out 1: request is for a visible pixel
- `rgb_in` in RGB_W: pixel for the request issued LATENCY cycles earlier
- `rgb_out` out RGB_W: pixel to display; 0 outside de
- `hsync` out 1: horizontal sync
- `vsync` out 1: vertical sync
- `de` out 1: data enable
- `frame_start` out 1: one-cycle pulse with output pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined likewise.
- Counters `h_cnt` 0..H_TOTAL-1 and `v_cnt` 0..V_TOTAL-1. Both reset to 0.
- `h_cnt` increments every cycle and wraps to 0 at H_TOTAL-1.
- `v_cnt` increments when `h_cnt` wraps, and wraps to 0 at V_TOTAL-1 on the same edge.
- Raster order per line: active [0,H_ACTIVE), then FP, then SYNC at [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then BP. The vertical axis uses the same order in lines.
- Request stage (counter decode, no extra register):
  - `req_x`=`h_cnt`, `req_y`=`v_cnt`.
  - `req_valid` = (`h_cnt`<H_ACTIVE) && (`v_cnt`<V_ACTIVE).
- Alignment pipeline:
  - Raw de/hs/vs/fs flags are computed from the counters and delayed LATENCY+1 registers.
  - `rgb_in` is registered once into `rgb_out`, masked to 0 when the delayed de is 0.
  - fs raw = (`h_cnt`==0 && `v_cnt`==0).
  - vsync changes only on line boundaries, coincident with hsync-stage alignment of `h_cnt`==0.
- Sync outputs: asserted level is HS_POL/VS_POL; inactive level is the inverse.

## Timing
- Cycle 0 is the clock period ending at the first rising edge with `rst_n` high. Counters read (0,0) in cycle 0 and advance once per cycle.
- A request in cycle c must be answered on `rgb_in` at the end of cycle c+LATENCY. The matching `rgb_out`/de/hsync/vsync/frame_start appear in cycle c+LATENCY+1.
- Total request-to-output latency is LATENCY+1. LATENCY=0 means upstream answers combinationally in the same cycle.
- Reset values:
  - `req_x`=0, `req_y`=0, `req_valid`=1.
  - `rgb_out`=0, `de`=0, `frame_start`=0.
  - `hsync`=~HS_POL, `vsync`=~VS_POL.
  - All pipeline stages reset to these inactive values.
- Outputs stay inactive for cycles 0..LATENCY. The first output, (0,0) with `frame_start`=1, appears in cycle LATENCY+1.
- Reset asserted mid-frame: all state clears immediately (asynchronous), with no partial flush. Timing restarts at (0,0) per the rule above.
- `rgb_in` is ignored for requests with `req_valid`=0. Its value never leaks to `rgb_out` during blanking.
- Frame period is exactly H_TOTAL*V_TOTAL cycles. `frame_start` pulses exactly once per frame.

## Test plan
All scenarios use H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), LATENCY=2, pols=1, unless stated.
- Reset release: outputs inactive for cycles 0..2. Cycle 3 gives `de`=1, `frame_start`=1, and `rgb_out` = the value driven on `rgb_in` in cycle 2.
- Raster: model returns `rgb_in`={req_y,req_x} delayed 2 cycles. Every `de` cycle must show `rgb_out` matching the expected (x,y) in raster order, with 4 de cycles per line and 12 per frame.
- Sync placement:
  - hsync is high for 2 cycles starting 5 cycles after each line's first de.
  - vsync is high for 8 cycles, starting 32 cycles after the frame's first de.
  - frame_start repeats every 48 cycles.
- Blanking mask: drive `rgb_in`=24'hFFFFFF constantly. `rgb_out` must be 0 whenever `de`=0 and FFFFFF whenever `de`=1.
- Mid-frame reset: assert `rst_n`=0 asynchronously at v=1,h=2. All outputs go to reset values immediately. After release, the frame restarts with `frame_start` 3 cycles later.
- LATENCY=0 and default 1280x720 parameters:
  - output latency is 1 cycle;
  - frame period is 1650*750=1237500 cycles;
  - `req_x` never exceeds 1649.
